// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared state encoding, width helper and idle level for the serial word feeder
package ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  // Ceiling log2 usable in parameter/localparam expressions.
  function automatic int ser_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ser_word_fifo.sv
// rtl/ser_word_fifo.sv - synchronous word FIFO feeding the serial shifter
module ser_word_fifo
  import ser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           rd_en,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [ser_clog2(DEPTH):0]      count
);

  localparam int PTR_W = ser_clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage is data-only; validity is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
        count <= count + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - buffers parallel words and shifts them out one bit per clock
module serial_word_feeder
  import ser_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   DEPTH      = 4,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int CNT_W  = ser_clog2(DATA_W);
  localparam int FCNT_W = ser_clog2(DEPTH) + 1;

  ser_state_t        state;
  ser_state_t        next_state;
  logic              load;
  logic              shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              ser_out_q;

  logic              fifo_wr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [FCNT_W-1:0] fifo_count;

  // in_ready depends only on registered occupancy, and is held low during reset.
  assign in_ready = !rst && !fifo_full;
  assign fifo_wr  = in_valid && in_ready;

  ser_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (in_data),
    .rd_en   (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Shifter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Decide whether to load a new word, shift the current one, or fall idle.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt != '0) begin
          shift = 1'b1;
        end else if (!fifo_empty) begin
          // Back-to-back: the next word's first bit follows the last bit directly.
          load = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Shift register, bit counter and the registered serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      ser_out_q <= IDLE_LEVEL;
    end else if (load) begin
      bit_cnt <= CNT_W'(DATA_W - 1);
      if (MSB_FIRST) begin
        ser_out_q <= fifo_rd_data[DATA_W-1];
        shreg     <= fifo_rd_data << 1;
      end else begin
        ser_out_q <= fifo_rd_data[0];
        shreg     <= fifo_rd_data >> 1;
      end
    end else if (shift) begin
      bit_cnt <= bit_cnt - CNT_W'(1);
      if (MSB_FIRST) begin
        ser_out_q <= shreg[DATA_W-1];
        shreg     <= shreg << 1;
      end else begin
        ser_out_q <= shreg[0];
        shreg     <= shreg >> 1;
      end
    end else begin
      ser_out_q <= IDLE_LEVEL;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = (state == ST_SHIFT);
  assign word_done = (state == ST_SHIFT) && (bit_cnt == '0);
  assign busy      = (fifo_count != '0) || (state == ST_SHIFT);

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb/tb_serial_word_feeder.sv - directed self-checking bench for serial_word_feeder
module tb_serial_word_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       word_done;
  logic       busy;

  logic [7:0] l_in_data;
  logic       l_in_valid;
  logic       l_in_ready;
  logic       l_ser_out;
  logic       l_ser_valid;
  logic       l_word_done;
  logic       l_busy;

  int total;
  int bad;

  serial_word_feeder #(
    .DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .word_done(word_done), .busy(busy)
  );

  serial_word_feeder #(
    .DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) dut_lsb (
    .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .word_done(l_word_done), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] wq [3];
    logic [7:0] wv [6];
    int idx;
    int k;

    total = 0;
    bad = 0;
    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    l_in_data = 8'h00;
    l_in_valid = 1'b0;

    // 1: reset for two cycles, then release
    tick();
    check("ready_in_reset", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_ser_valid", ser_valid, 1'b0);
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_word_done", word_done, 1'b0);

    // 2: single word 8'hA5, MSB first
    pat = 8'hA5;
    in_data = pat;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("w1_busy_after_write", busy, 1'b1);
    check("w1_no_bit_yet", ser_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("w1_bit%0d", i), ser_out, pat[7-i]);
      check($sformatf("w1_valid%0d", i), ser_valid, 1'b1);
      check($sformatf("w1_done%0d", i), word_done, (i == 7) ? 1'b1 : 1'b0);
    end
    tick();
    check("w1_end_valid", ser_valid, 1'b0);
    check("w1_end_out", ser_out, 1'b0);
    check("w1_end_busy", busy, 1'b0);

    // 3: three words on consecutive edges stream with no gap
    wq[0] = 8'hA5;
    wq[1] = 8'h0F;
    wq[2] = 8'hF0;
    in_data = wq[0];
    in_valid = 1'b1;
    tick();
    in_data = wq[1];
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 0) in_data = wq[2];
      if (i == 1) in_valid = 1'b0;
      pat = wq[i/8];
      check($sformatf("s3_bit%0d", i), ser_out, pat[7-(i%8)]);
      check($sformatf("s3_valid%0d", i), ser_valid, 1'b1);
      check($sformatf("s3_done%0d", i), word_done, ((i % 8) == 7) ? 1'b1 : 1'b0);
    end
    tick();
    check("s3_end_valid", ser_valid, 1'b0);

    // 4: hold in_valid with six words; FIFO fills, 6th accepted only at edge 11
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33;
    wv[3] = 8'h44; wv[4] = 8'h55; wv[5] = 8'h66;
    idx = 0;
    for (int e = 1; e <= 50; e++) begin
      in_valid = (idx < 6);
      in_data = (idx < 6) ? wv[idx] : 8'h00;
      tick();
      if (in_valid && (e <= 5 || e == 11)) idx++;
      if (e <= 12) begin
        check($sformatf("s4_ready_e%0d", e), in_ready, (e <= 4 || e == 10) ? 1'b1 : 1'b0);
      end
      if (e >= 2 && e <= 49) begin
        k = e - 2;
        pat = wv[k/8];
        check($sformatf("s4_bit_e%0d", e), ser_out, pat[7-(k%8)]);
        check($sformatf("s4_valid_e%0d", e), ser_valid, 1'b1);
        check($sformatf("s4_done_e%0d", e), word_done, ((k % 8) == 7) ? 1'b1 : 1'b0);
      end
    end
    check("s4_end_valid", ser_valid, 1'b0);
    check("s4_end_busy", busy, 1'b0);
    in_valid = 1'b0;

    // 5: LSB-first instance, 8'h05 -> 1,0,1,0,0,0,0,0
    pat = 8'h05;
    l_in_data = pat;
    l_in_valid = 1'b1;
    tick();
    l_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("lsb_bit%0d", i), l_ser_out, (i == 0 || i == 2) ? 1'b1 : 1'b0);
      check($sformatf("lsb_done%0d", i), l_word_done, (i == 7) ? 1'b1 : 1'b0);
    end
    tick();
    check("lsb_end_valid", l_ser_valid, 1'b0);

    // 6: reset during bit 3 of the first of two words
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("s6_bit3", ser_out, 1'b0);
    check("s6_busy_pre", busy, 1'b1);
    check("s6_valid_pre", ser_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("s6_rst_valid", ser_valid, 1'b0);
    check("s6_rst_out", ser_out, 1'b0);
    check("s6_rst_busy", busy, 1'b0);
    check("s6_rst_done", word_done, 1'b0);
    check("s6_rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("s6_post_valid%0d", i), ser_valid, 1'b0);
      check($sformatf("s6_post_busy%0d", i), busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
